control_fsm: RTL

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/control_fsm.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit for an RV32I-style datapath.
// Define BRANCH_EN to decode conditional branches; otherwise BRANCH is handled as an illegal opcode.
module control_fsm #(
    parameter logic [31:0] INSTRET_RESET = '0
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic        zero,
    output logic        load_ir,
    output logic        load_pc,
    output logic        WE_RF,
    output logic        WE_MEM,
    output logic        ULA_din2_sel,
    output logic [1:0]  RF_din_sel,
    output logic        pc_adder_sel,
    output logic        pc_next_sel,
    output logic [3:0]  alu_op,
    output logic        illegal,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    state_t     state;
    logic       load_ir_d, load_pc_d, we_rf_d, we_mem_d;
    logic       din2_sel_d, adder_sel_d, next_sel_d, illegal_d;
    logic [1:0] rf_sel_d;
    logic [3:0] alu_op_d;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state   <= FETCH;
            instret <= INSTRET_RESET;
        end else begin
            if (load_pc_d) instret <= instret + 32'd1;
            case (state)
                FETCH:   state <= DECODE;
                DECODE:  state <= EXEC;
                EXEC:    state <= (opcode == OPC_LOAD) ? MEM : FETCH;
                MEM:     state <= WB;
                WB:      state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        load_ir_d   = 1'b0;
        load_pc_d   = 1'b0;
        we_rf_d     = 1'b0;
        we_mem_d    = 1'b0;
        din2_sel_d  = 1'b0;
        adder_sel_d = 1'b0;
        next_sel_d  = 1'b0;
        illegal_d   = 1'b0;
        rf_sel_d    = 2'd0;
        alu_op_d    = 4'd0;
        case (state)
            FETCH: load_ir_d = 1'b1;
            EXEC: begin
                case (opcode)
                    OPC_OP: begin
                        load_pc_d = 1'b1;
                        we_rf_d   = 1'b1;
                        rf_sel_d  = 2'd1;
                        alu_op_d  = {funct7_5, funct3};
                    end
                    OPC_OPIMM: begin
                        load_pc_d  = 1'b1;
                        we_rf_d    = 1'b1;
                        din2_sel_d = 1'b1;
                        rf_sel_d   = 2'd1;
                        // bit 30 of an I-type immediate is only an opcode modifier for shifts-right
                        alu_op_d   = {(funct3 == 3'b101) & funct7_5, funct3};
                    end
                    OPC_AUIPC: begin
                        load_pc_d   = 1'b1;
                        we_rf_d     = 1'b1;
                        rf_sel_d    = 2'd3;
                        adder_sel_d = 1'b1;
                    end
                    OPC_JAL: begin
                        load_pc_d   = 1'b1;
                        we_rf_d     = 1'b1;
                        rf_sel_d    = 2'd2;
                        adder_sel_d = 1'b1;
                        next_sel_d  = 1'b1;
                    end
                    OPC_JALR: begin
                        load_pc_d  = 1'b1;
                        we_rf_d    = 1'b1;
                        rf_sel_d   = 2'd2;
                        next_sel_d = 1'b1;
                    end
                    OPC_STORE: begin
                        load_pc_d  = 1'b1;
                        we_mem_d   = 1'b1;
                        din2_sel_d = 1'b1;
                    end
                    OPC_LOAD: din2_sel_d = 1'b1;
`ifdef BRANCH_EN
                    OPC_BRANCH: begin
                        load_pc_d   = 1'b1;
                        adder_sel_d = 1'b1;
                        next_sel_d  = zero ^ funct3[0];
                        alu_op_d    = 4'b1000;
                    end
`endif
                    default: begin
                        load_pc_d = 1'b1;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEM: din2_sel_d = 1'b1;
            WB: begin
                din2_sel_d = 1'b1;
                we_rf_d    = 1'b1;
                load_pc_d  = 1'b1;
            end
            default: ;
        endcase
    end

`ifndef BRANCH_EN
    logic unused_zero;
    assign unused_zero = zero;
`endif

    // Outputs are forced low while reset is held even though the state already reads FETCH.
    always_comb begin
        load_ir      = 1'b0;
        load_pc      = 1'b0;
        WE_RF        = 1'b0;
        WE_MEM       = 1'b0;
        ULA_din2_sel = 1'b0;
        RF_din_sel   = '0;
        pc_adder_sel = 1'b0;
        pc_next_sel  = 1'b0;
        alu_op       = '0;
        illegal      = 1'b0;
        if (reset) begin
            load_ir      = load_ir_d;
            load_pc      = load_pc_d;
            WE_RF        = we_rf_d;
            WE_MEM       = we_mem_d;
            ULA_din2_sel = din2_sel_d;
            RF_din_sel   = rf_sel_d;
            pc_adder_sel = adder_sel_d;
            pc_next_sel  = next_sel_d;
            alu_op       = alu_op_d;
            illegal      = illegal_d;
        end
    end

endmodule
